// File: rtl/fsm_acceso.sv
// rtl/fsm_acceso.sv - doorway access-lane controller: filtered sensors, direction FSM, occupancy count, transit timeout
module fsm_acceso #(
    parameter int DEB_CYCLES = 4,
    parameter int CAP        = 15,
    parameter int CNT_W      = 4,
    parameter int TMO_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             S1,
    input  logic             S2,
    output logic             V,
    output logic             R,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             err
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(TMO_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        IN_A,
        IN_B,
        IN_C,
        OUT_A,
        OUT_B,
        OUT_C,
        FAULT
    } state_t;

    // bit 0 carries S1, bit 1 carries S2
    logic [1:0]    meta;
    logic [1:0]    sync;
    logic [1:0]    filt;
    logic [DW-1:0] deb_cnt [0:1];

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [TW-1:0]    tmr;
    logic [TW-1:0]    tmr_nxt;
    logic             s1f;
    logic             s2f;
    logic             transit;

    assign s1f = filt[0];
    assign s2f = filt[1];

    // Two-flop synchronisers followed by a stability counter per sensor;
    // the filtered level flips once the synchronised level has disagreed
    // with it on DEB_CYCLES+1 consecutive edges, which lands the change
    // DEB_CYCLES+2 edges after the raw level is first sampled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= '0;
            sync <= '0;
            filt <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            meta <= {S2, S1};
            sync <= meta;
            for (int i = 0; i < 2; i++) begin
                if (sync[i] != filt[i]) begin
                    if (deb_cnt[i] == DW'(DEB_CYCLES)) begin
                        filt[i]    <= sync[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign transit = (state != IDLE) && (state != FAULT);

    // State, occupancy and transit timer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            count <= '0;
            tmr   <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            tmr   <= tmr_nxt;
        end
    end

    // Next-state and occupancy update from the filtered sensor pair; the
    // timeout only fires on a cycle where no sensor-driven move happens.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        tmr_nxt   = '0;
        case (state)
            IDLE: begin
                case ({s1f, s2f})
                    2'b10:   state_nxt = IN_A;
                    2'b01:   state_nxt = OUT_A;
                    2'b11:   state_nxt = FAULT;
                    default: state_nxt = IDLE;
                endcase
            end
            IN_A: begin
                if ({s1f, s2f} == 2'b11) state_nxt = IN_B;
                else if ({s1f, s2f} == 2'b00) state_nxt = IDLE;
            end
            IN_B: begin
                if ({s1f, s2f} == 2'b01) state_nxt = IN_C;
                else if ({s1f, s2f} == 2'b10) state_nxt = IN_A;
                else if ({s1f, s2f} == 2'b00) state_nxt = IDLE;
            end
            IN_C: begin
                if ({s1f, s2f} == 2'b00) begin
                    if (count == CNT_W'(CAP)) begin
                        state_nxt = FAULT;
                    end else begin
                        state_nxt = IDLE;
                        count_nxt = count + 1'b1;
                    end
                end else if ({s1f, s2f} == 2'b11) begin
                    state_nxt = IN_B;
                end
            end
            OUT_A: begin
                if ({s1f, s2f} == 2'b11) state_nxt = OUT_B;
                else if ({s1f, s2f} == 2'b00) state_nxt = IDLE;
            end
            OUT_B: begin
                if ({s1f, s2f} == 2'b10) state_nxt = OUT_C;
                else if ({s1f, s2f} == 2'b01) state_nxt = OUT_A;
                else if ({s1f, s2f} == 2'b00) state_nxt = IDLE;
            end
            OUT_C: begin
                if ({s1f, s2f} == 2'b00) begin
                    if (count == '0) begin
                        state_nxt = FAULT;
                    end else begin
                        state_nxt = IDLE;
                        count_nxt = count - 1'b1;
                    end
                end else if ({s1f, s2f} == 2'b11) begin
                    state_nxt = OUT_B;
                end
            end
            FAULT: begin
                if ({s1f, s2f} == 2'b00) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (transit && (state_nxt == state)) begin
            if (tmr == TW'(TMO_CYCLES - 1)) begin
                state_nxt = FAULT;
            end else begin
                tmr_nxt = tmr + 1'b1;
            end
        end
    end

    // Lights and flags decode only registered state and count.
    assign V    = (state == IDLE) && (count < CNT_W'(CAP));
    assign R    = ~V;
    assign full = (count == CNT_W'(CAP));
    assign err  = (state == FAULT);

endmodule
